usb_utmi_tx_arb: RTL and testbench

- Shares the single UTMI transmit path of the USB PHY among N packet sources: handshake, token/SOF and endpoint data engines.
- Arbitrates whole packets round-robin and drives DataOut/TxValid with full TxReady flow control.
- Enforces the bus turnaround and inter-packet gap after every transmitted or received packet.
- Sits between the protocol layer and the PHY's UTMI transmit/receive-status pins.

---
 rtl/usb_tx_arb_pkg.sv | 27 ++
 rtl/usb_rr_pick.sv | 38 +++
 rtl/usb_utmi_tx_arb.sv | 160 ++++++++++++++++
 tb/tb_usb_utmi_tx_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_arb_pkg.sv
// Shared constants for the UTMI transmit arbiter family: FSM state
// encodings, UTMI byte width, default inter-packet gap and a small
// one-hot to index helper.
package usb_tx_arb_pkg;

    localparam int UTMI_W         = 8;
    localparam int IPG_CYCLES_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_IPG  = 2'd2;

    // Index of the set bit in a one-hot vector of up to 8 requesters.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// set request at or above the pointer, searching upward with wrap-around.
// All zeros when no request is set.
module usb_rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    // Pick the request with the smallest upward distance from the pointer.
    always_comb begin
        int best_d;
        int best_j;
        int d;
        int p;
        best_d = N;
        best_j = 0;
        d      = 0;
        p      = int'(i_ptr);
        o_gnt  = '0;
        for (int j = 0; j < N; j++) begin
            d = (j >= p) ? (j - p) : (j - p + N);
            if (i_req[j] && (d < best_d)) begin
                best_d = d;
                best_j = j;
            end else begin
                best_d = best_d;
            end
        end
        for (int j = 0; j < N; j++) begin
            o_gnt[j] = (best_d < N) && (best_j == j);
        end
    end

endmodule

// File: rtl/usb_utmi_tx_arb.sv
// UTMI transmit arbiter: shares the PHY transmit path among N_REQ packet
// sources, granting whole packets round-robin, with TxReady flow control,
// abort on request drop and an enforced bus gap after every transmitted or
// received packet.
// Optional build macro USB_TX_ARB_PRIO_EN: requester 0 (handshake engine)
// wins outright whenever it requests in IDLE; others stay round-robin.
module usb_utmi_tx_arb
    import usb_tx_arb_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int IPG_CYCLES = IPG_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [UTMI_W*N_REQ-1:0] data_i,
    input  logic [N_REQ-1:0]        last_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [UTMI_W-1:0]       DataOut_o,
    output logic                    TxValid_o,
    input  logic                    TxReady_i,
    input  logic                    RxActive_i,
    output logic                    busy_o,
    output logic                    abort_o
);

    localparam int          PW         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]  IPG_RELOAD = 8'(IPG_CYCLES - 1);

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic             r_txvalid;
    logic             r_abort;
    logic [PW-1:0]    r_rr_ptr;
    logic [7:0]       r_ipg_cnt;

    logic [N_REQ-1:0] w_req_rr;
    logic [N_REQ-1:0] w_pick;
    logic [N_REQ-1:0] w_win;
    logic             w_upd_ptr;
    logic [7:0]       w_win8;
    logic [2:0]       w_win_idx;
    logic [2:0]       w_nxt_idx;
    logic             w_fire;
    logic             w_gnt_req;
    logic             w_gnt_last;

`ifdef USB_TX_ARB_PRIO_EN
    assign w_req_rr = req_i & ~{{(N_REQ-1){1'b0}}, 1'b1};
`else
    assign w_req_rr = req_i;
`endif

    usb_rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .i_req (w_req_rr),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick)
    );

    // Final winner; a requester-0 priority win leaves the pointer alone.
    always_comb begin
        w_win     = w_pick;
        w_upd_ptr = 1'b1;
`ifdef USB_TX_ARB_PRIO_EN
        if (req_i[0]) begin
            w_win     = {{(N_REQ-1){1'b0}}, 1'b1};
            w_upd_ptr = 1'b0;
        end else begin
            w_win     = w_pick;
            w_upd_ptr = 1'b1;
        end
`endif
    end

    assign w_win8     = 8'(w_win);
    assign w_win_idx  = onehot_to_idx(w_win8);
    assign w_nxt_idx  = (w_win_idx == 3'(N_REQ - 1)) ? 3'd0 : (w_win_idx + 3'd1);
    assign w_fire     = r_txvalid & TxReady_i;
    assign w_gnt_req  = |(r_gnt & req_i);
    assign w_gnt_last = |(r_gnt & last_i);

    // Packet-level FSM: grant, stream bytes, then hold the bus gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_txvalid <= 1'b0;
            r_abort   <= 1'b0;
            r_rr_ptr  <= '0;
            r_ipg_cnt <= 8'd0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A receive in progress blocks grants and, once over,
                    // still costs a full gap before we may transmit.
                    if (RxActive_i) begin
                        r_state   <= ST_IPG;
                        r_ipg_cnt <= IPG_RELOAD;
                    end else if (|req_i) begin
                        r_state   <= ST_SEND;
                        r_gnt     <= w_win;
                        r_txvalid <= 1'b1;
                        if (w_upd_ptr) begin
                            r_rr_ptr <= w_nxt_idx[PW-1:0];
                        end
                    end
                end
                ST_SEND: begin
                    // Dropping TxValid mid-packet is how UTMI signals abort.
                    if (!w_gnt_req) begin
                        r_state   <= ST_IPG;
                        r_gnt     <= '0;
                        r_txvalid <= 1'b0;
                        r_abort   <= 1'b1;
                        r_ipg_cnt <= IPG_RELOAD;
                    end else if (w_fire && w_gnt_last) begin
                        r_state   <= ST_IPG;
                        r_gnt     <= '0;
                        r_txvalid <= 1'b0;
                        r_ipg_cnt <= IPG_RELOAD;
                    end
                end
                ST_IPG: begin
                    if (RxActive_i) begin
                        r_ipg_cnt <= IPG_RELOAD;
                    end else if (r_ipg_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ipg_cnt <= r_ipg_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gnt     <= '0;
                    r_txvalid <= 1'b0;
                end
            endcase
        end
    end

    // Byte mux: granted requester's byte, zero when nobody holds the bus.
    always_comb begin
        DataOut_o = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            DataOut_o = DataOut_o | (data_i[UTMI_W*i +: UTMI_W] & {UTMI_W{r_gnt[i]}});
        end
    end

    assign ack_o     = r_gnt & {N_REQ{w_fire}};
    assign gnt_o     = r_gnt;
    assign TxValid_o = r_txvalid;
    assign busy_o    = (r_state != ST_IDLE);
    assign abort_o   = r_abort;

endmodule

// File: tb/tb_usb_utmi_tx_arb.sv
// Randomized bench for usb_utmi_tx_arb with a packet-level reference model:
// sources hold byte payloads, the model tracks which packet owns the bus
// and how many quiet cycles have elapsed since the bus last went idle.
module tb_usb_utmi_tx_arb;

    localparam int N   = 3;
    localparam int IPG = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic [7:0]     dout;
    logic           txv;
    logic           ready;
    logic           rx;
    logic           busy;
    logic           abort;

    always #5 clk = ~clk;

    usb_utmi_tx_arb #(.N_REQ(N), .IPG_CYCLES(IPG)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .data_i     (data),
        .last_i     (last),
        .ack_o      (ack),
        .gnt_o      (gnt),
        .DataOut_o  (dout),
        .TxValid_o  (txv),
        .TxReady_i  (ready),
        .RxActive_i (rx),
        .busy_o     (busy),
        .abort_o    (abort)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Source payloads: pos < len means a packet is pending.
    int pay [N][8];
    int len [N];
    int pos [N];
    int rx_left = 0;

    // Reference model state.
    bit           m_active;
    int           m_win;
    logic [N-1:0] m_gnt;
    bit           m_abort;
    int           m_ptr;
    int           m_quiet;
    int           wait_cnt [N];

    int p_req, p_ready, p_rx, p_abort, p_rst;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((int'(v) >> i) & 1) == 1;
    endfunction

    function automatic int rr_first(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (bit_of(v, (ptr + k) % N)) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic end_packet();
        m_active = 1'b0;
        m_gnt    = '0;
        m_quiet  = 0;
    endtask

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_step();
        int  w;
        bit  lst;
        if (rst) begin
            m_active = 1'b0;
            m_gnt    = '0;
            m_abort  = 1'b0;
            m_ptr    = 0;
            m_quiet  = IPG;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            return;
        end
        m_abort = 1'b0;
        if (m_active) begin
            w   = m_win;
            lst = (len[w] - pos[w] == 1);
            if (!bit_of(req, w)) begin
                end_packet();
                m_abort = 1'b1;
            end else if (ready) begin
                pos[w]++;
                if (lst) end_packet();
            end
        end else if (!rx && (req != '0) && (m_quiet >= IPG)) begin
`ifdef USB_TX_ARB_PRIO_EN
            if (bit_of(req, 0)) begin
                w = 0;
            end else begin
                w     = rr_first(req & 3'b110, m_ptr);
                m_ptr = (w + 1) % N;
            end
`else
            w     = rr_first(req, m_ptr);
            m_ptr = (w + 1) % N;
            check_eq("starve", 32'(wait_cnt[w] <= N - 1), 32'd1);
`endif
            for (int i = 0; i < N; i++) begin
                if (i != w && bit_of(req, i)) wait_cnt[i]++;
            end
            wait_cnt[w] = 0;
            m_active = 1'b1;
            m_win    = w;
            m_gnt    = N'(1 << w);
        end else if (rx) begin
            m_quiet = 0;
        end else if (m_quiet < IPG) begin
            m_quiet++;
        end
    endtask

    task automatic start_packet(input int i);
        len[i] = $urandom_range(1, 5);
        pos[i] = 0;
        for (int k = 0; k < 8; k++) pay[i][k] = $urandom_range(0, 255);
        wait_cnt[i] = 0;
    endtask

    // Drive fresh inputs for the next edge.
    task automatic drive(input int cyc);
        rst   = (cyc < 2) || ($urandom_range(0, 99) < p_rst);
        ready = ($urandom_range(0, 99) < p_ready);
        if (rx_left > 0) begin
            rx_left--;
        end else if ($urandom_range(0, 99) < p_rx) begin
            rx_left = $urandom_range(1, 20);
        end
        rx = (rx_left > 0);
        if (cyc == 4) begin
            len[0] = 3; pos[0] = 0;
            pay[0][0] = 8'h2D; pay[0][1] = 8'h01; pay[0][2] = 8'hE8;
        end
        for (int i = 0; i < N; i++) begin
            if (pos[i] >= len[i]) begin
                if (cyc >= 60 && $urandom_range(0, 99) < p_req) start_packet(i);
            end else if (m_active && m_win == i && (len[i] - pos[i] > 1)
                         && $urandom_range(0, 99) < p_abort) begin
                pos[i] = len[i];
            end
        end
        data = '0;
        for (int i = 0; i < N; i++) begin
            req[i]  = (pos[i] < len[i]);
            last[i] = (len[i] - pos[i] == 1);
            if (pos[i] < len[i]) data = data | ((8*N)'(pay[i][pos[i]]) << (8 * i));
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; data = '0; last = '0; ready = 1'b1; rx = 1'b0;
        for (int i = 0; i < N; i++) begin
            len[i] = 0; pos[i] = 0; wait_cnt[i] = 0;
        end
        m_active = 1'b0; m_win = 0; m_gnt = '0; m_abort = 1'b0; m_ptr = 0; m_quiet = IPG;
        p_req = 0; p_ready = 100; p_rx = 0; p_abort = 0; p_rst = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if      (cyc < 60)   begin p_req = 0;   p_ready = 100; p_rx = 0; p_abort = 0;  p_rst = 0; end
            else if (cyc < 800)  begin p_req = 100; p_ready = 100; p_rx = 0; p_abort = 0;  p_rst = 0; end
            else if (cyc < 1600) begin p_req = 60;  p_ready = 50;  p_rx = 0; p_abort = 0;  p_rst = 0; end
            else if (cyc < 2400) begin p_req = 50;  p_ready = 70;  p_rx = 5; p_abort = 0;  p_rst = 0; end
            else if (cyc < 3200) begin p_req = 70;  p_ready = 70;  p_rx = 2; p_abort = 10; p_rst = 0; end
            else                 begin p_req = 60;  p_ready = 60;  p_rx = 3; p_abort = 5;  p_rst = 1; end

            @(posedge clk);
            model_step();
            #1;
            check_eq("gnt",     32'(gnt),   32'(m_gnt));
            check_eq("txvalid", 32'(txv),   32'(m_active));
            check_eq("busy",    32'(busy),  32'(m_active || (m_quiet < IPG)));
            check_eq("abort",   32'(abort), 32'(m_abort));
            drive(cyc);
            #1;
            check_eq("ack",  32'(ack),  32'((m_active && ready) ? m_gnt : '0));
            check_eq("dout", 32'(dout), 32'(m_active ? 8'(data >> (8 * m_win)) : 8'h00));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
